// File: rtl/alu181_serial.sv
// Serial 74181-compatible ALU: one WIDTH-bit operation evaluated LSB-first,
// one 4-bit slice per clock, with the carry rippled through a register.
module alu181_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cn4_n,
    output logic             a_b
);

    //  state | meaning
    //  IDLE  | ready for a new operation, operands not yet captured
    //  RUN   | evaluating slice k_q, carry held in c_q
    //  DONE  | result stable on f/cn4_n/a_b, waiting for out_ready
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d;
    logic             c_q, c_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             cn4_n_q, cn4_n_d;
    logic             a_b_q, a_b_d;

    logic [KW+1:0]    base;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [3:0]       a_sl, b_sl, x_sl, y_sl, f_sl;
    logic [4:0]       sum_sl;

    // Evaluate the current slice from the captured operands and carry register.
    always_comb begin
        base   = {k_q, 2'b00};
        a_sh   = a_q >> base;
        b_sh   = b_q >> base;
        a_sl   = a_sh[3:0];
        b_sl   = b_sh[3:0];
        x_sl   = a_sl | ({4{s_q[0]}} & b_sl) | ({4{s_q[1]}} & ~b_sl);
        y_sl   = ({4{s_q[3]}} & a_sl & b_sl) | ({4{s_q[2]}} & a_sl & ~b_sl);
        sum_sl = {1'b0, x_sl} + {1'b0, y_sl} + {4'b0000, c_q};
        f_sl   = m_q ? ~(x_sl ^ y_sl) : sum_sl[3:0];
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        m_d     = m_q;
        c_d     = c_q;
        k_d     = k_q;
        f_d     = f_q;
        cn4_n_d = cn4_n_q;
        a_b_d   = a_b_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    s_d     = s;
                    m_d     = m;
                    c_d     = ~cn_n;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                f_d = (f_q & ~(WIDTH'(4'hF) << base)) | (WIDTH'(f_sl) << base);
                c_d = sum_sl[4];
                if (k_q == KW'(NSLICE - 1)) begin
                    cn4_n_d = ~sum_sl[4];
                    a_b_d   = &f_d;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            c_q     <= 1'b0;
            k_q     <= '0;
            f_q     <= '0;
            cn4_n_q <= 1'b1;
            a_b_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            m_q     <= m_d;
            c_q     <= c_d;
            k_q     <= k_d;
            f_q     <= f_d;
            cn4_n_q <= cn4_n_d;
            a_b_q   <= a_b_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign f         = f_q;
    assign cn4_n     = cn4_n_q;
    assign a_b       = a_b_q;

endmodule

// File: tb/tb_alu181_serial.sv
// Bench for alu181_serial: three instances (WIDTH 4, 16, 32) share one
// stimulus stream; the 16-bit instance is checked against hand values,
// the others against a whole-word X/Y reference model.
module tb_alu181_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic [31:0] a_in, b_in;
    logic [3:0]  s_in;
    logic        m_in, cn_in;

    logic        in_ready4, out_valid4, cn4_n4, a_b4;
    logic [3:0]  f4;
    logic        in_ready16, out_valid16, cn4_n16, a_b16;
    logic [15:0] f16;
    logic        in_ready32, out_valid32, cn4_n32, a_b32;
    logic [31:0] f32;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu181_serial #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a_in[3:0]), .b(b_in[3:0]), .s(s_in), .m(m_in), .cn_n(cn_in),
        .out_valid(out_valid4), .out_ready(out_ready), .f(f4),
        .cn4_n(cn4_n4), .a_b(a_b4));

    alu181_serial #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a_in[15:0]), .b(b_in[15:0]), .s(s_in), .m(m_in), .cn_n(cn_in),
        .out_valid(out_valid16), .out_ready(out_ready), .f(f16),
        .cn4_n(cn4_n16), .a_b(a_b16));

    alu181_serial #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .a(a_in), .b(b_in), .s(s_in), .m(m_in), .cn_n(cn_in),
        .out_valid(out_valid32), .out_ready(out_ready), .f(f32),
        .cn4_n(cn4_n32), .a_b(a_b32));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input int w, input logic [31:0] ta, input logic [31:0] tb_v,
                                  input logic [3:0] ts, input logic tm, input logic tc,
                                  output logic [31:0] ef, output logic ec, output logic eab);
        logic [31:0] mask, x, y;
        logic [32:0] sum;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        x    = (ta | (ts[0] ? tb_v : 32'h0) | (ts[1] ? ~tb_v : 32'h0)) & mask;
        y    = ((ts[3] ? (ta & tb_v) : 32'h0) | (ts[2] ? (ta & ~tb_v) : 32'h0)) & mask;
        sum  = {1'b0, x} + {1'b0, y} + {32'h0, ~tc};
        ec   = ~sum[w];
        ef   = tm ? (~(x ^ y) & mask) : (sum[31:0] & mask);
        eab  = (ef == mask);
    endfunction

    // Issue one op to all instances, measure latency, hold DONE for 'hold'
    // cycles with junk on the inputs, then retire it.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [3:0] ts, input logic tm, input logic tc,
                          input logic [15:0] ef, input logic ec, input logic eab, input int hold);
        int lat4 = 0, lat16 = 0, lat32 = 0;
        logic [31:0] mf;
        logic mc, mab;
        check({tag, " in_ready before"}, {31'b0, in_ready16}, 32'd1);
        a_in = ta; b_in = tb_v; s_in = ts; m_in = tm; cn_in = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in = $urandom; b_in = $urandom; s_in = 4'($urandom); m_in = ~tm; cn_in = ~tc;
        check({tag, " in_ready after accept"}, {31'b0, in_ready16}, 32'd0);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (out_valid4  && lat4  == 0) lat4  = c;
            if (out_valid16 && lat16 == 0) lat16 = c;
            if (out_valid32 && lat32 == 0) lat32 = c;
            if (lat4 != 0 && lat16 != 0 && lat32 != 0) break;
        end
        check({tag, " lat16"}, lat16, 32'd4);
        check({tag, " f16"}, {16'b0, f16}, {16'b0, ef});
        check({tag, " cn4_n16"}, {31'b0, cn4_n16}, {31'b0, ec});
        check({tag, " a_b16"}, {31'b0, a_b16}, {31'b0, eab});
        model(4, ta, tb_v, ts, tm, tc, mf, mc, mab);
        check({tag, " lat4"}, lat4, 32'd1);
        check({tag, " w4 result"}, {26'b0, f4, cn4_n4, a_b4}, {26'b0, mf[3:0], mc, mab});
        model(32, ta, tb_v, ts, tm, tc, mf, mc, mab);
        check({tag, " lat32"}, lat32, 32'd8);
        check({tag, " f32"}, f32, mf);
        check({tag, " w32 flags"}, {30'b0, cn4_n32, a_b32}, {30'b0, mc, mab});
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid; a_in = $urandom; b_in = $urandom;
            @(posedge clk); #1;
            check({tag, " hold result"}, {13'b0, out_valid16, in_ready16, f16, cn4_n16, a_b16},
                  {13'b0, 1'b1, 1'b0, ef, ec, eab});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " retire"}, {30'b0, out_valid16, in_ready16}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb, ef;
        logic [3:0]  rs;
        logic        rm, rc, ec, eab;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; s_in = '0; m_in = 1'b0; cn_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset 16", {12'b0, in_ready16, out_valid16, f16, cn4_n16, a_b16},
              {12'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
        check("reset 32", {f32}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add",   32'h0000_1234, 32'h0000_0FFF, 4'b1001, 1'b0, 1'b1, 16'h2233, 1'b1, 1'b0, 0);
        run_op("sub_n", 32'h0000_0005, 32'h0000_0007, 4'b0110, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0, 0);
        run_op("sub_p", 32'h0000_0007, 32'h0000_0005, 4'b0110, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0);
        run_op("cmp_eq", 32'h0000_5A5A, 32'h0000_5A5A, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 0);
        run_op("and",   32'h0000_F0F0, 32'h0000_FF00, 4'b1011, 1'b1, 1'b1, 16'hF000, 1'b0, 1'b0, 0);
        run_op("xor",   32'h0000_F0F0, 32'h0000_FF00, 4'b0110, 1'b1, 1'b1, 16'h0FF0, 1'b1, 1'b0, 0);
        run_op("ones",  32'h0000_1234, 32'h0000_5678, 4'b1100, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 0);
        run_op("not_a", 32'h0000_1234, 32'h0000_5678, 4'b0000, 1'b1, 1'b1, 16'hEDCB, 1'b1, 1'b0, 0);
        run_op("dec",   32'h0000_0000, 32'h0000_ABCD, 4'b1111, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 0);
        run_op("minus1", 32'h0000_8000, 32'h0000_0000, 4'b0011, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 0);
        run_op("backpr", 32'h0000_1234, 32'h0000_0FFF, 4'b1001, 1'b0, 1'b1, 16'h2233, 1'b1, 1'b0, 6);

        // Abort mid-RUN with an asynchronous reset.
        a_in = 32'h0000_1234; b_in = 32'h0000_0FFF; s_in = 4'b1001; m_in = 1'b0; cn_in = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort state", {12'b0, in_ready16, out_valid16, f16, cn4_n16, a_b16},
              {12'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("after_abort", 32'h0000_0001, 32'h0000_0001, 4'b1001, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rs = 4'($urandom);
            rm = 1'($urandom); rc = 1'($urandom);
            model(16, ra, rb, rs, rm, rc, ef, ec, eab);
            run_op($sformatf("rand%0d", i), ra, rb, rs, rm, rc, ef[15:0], ec, eab, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu181_serial.md
# alu181_serial

Parametrised, multi-cycle successor to the 4-bit 74181-style ALU slice. It accepts one WIDTH-bit operation via a valid/ready handshake and evaluates it LSB-first, one 4-bit slice per clock, rippling the carry through a register. It then holds the result until the consumer accepts it. It sits between the register-file read stage and writeback wherever a wide 74181-compatible function set is needed without a wide combinational carry chain.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, ≥ 4; NSLICE = WIDTH/4
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- a, b  in  WIDTH  operands (active-high data)
- s  in  4  function select, 74181 encoding
- m  in  1  1 = logic mode, 0 = arithmetic mode
- cn_n  in  1  active-low carry-in
- out_valid  out  1  result valid; high only in DONE
- out_ready  in  1  consumer accepts result
- f  out  WIDTH  result
- cn4_n  out  1  active-low carry-out of the MSB slice
- a_b  out  1  1 when f is all ones (equality flag for A−B−1)

## Operation
- Per bit i, with s[3:0]:
  - X_i = a_i | (s0 & b_i) | (s1 & ~b_i)
  - Y_i = (s3 & a_i & b_i) | (s2 & a_i & ~b_i)
- Arithmetic mode (m=0): f = X + Y + (~cn_n), computed modulo 2^WIDTH.
- Logic mode (m=1): f = ~(X ^ Y) bitwise. The carry chain still runs on X+Y+(~cn_n), but only cn4_n observes it.
- cn4_n = ~(carry out of bit WIDTH−1) in both modes. a_b = &f.
- Checks on the encoding:
  - m=0: s=1001 gives A+B; s=0110 gives A−B−1 (A−B with cn_n=0); s=1111 gives A−1; s=0011 gives −1.
  - m=1: s=1011 gives A&B; s=0110 gives A^B; s=1100 gives all ones; s=0000 gives ~A.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid=1, capture a, b, s, m, cn_n into operand registers, set carry register to ~cn_n, clear slice counter k, and go to RUN.
  - RUN: each cycle, evaluate slice k (bits 4k+3..4k) from the captured operands and the carry register. Write f[4k+3:4k], update the carry register with that slice's carry out, then increment k. After slice NSLICE−1: latch cn4_n and a_b, then go to DONE.
  - DONE: out_valid=1; f, cn4_n and a_b are stable. When out_ready=1, go to IDLE.
- in_valid is ignored outside IDLE. Input buses may change freely after capture.
- Slice counter width is clog2(NSLICE), with a minimum of 1 bit. k never wraps: the RUN→DONE transition happens on k = NSLICE−1.
- f keeps the previous result until it is overwritten slice by slice during RUN. f is meaningful only while out_valid=1.

## Timing
- Reset values (asynchronous, immediate on rst rising edge): state=IDLE, in_ready=1, out_valid=0, f=0, cn4_n=1, a_b=0, k=0, carry register=0.
- Reset during RUN or DONE aborts the operation; no result is produced.
- Handshake transfer occurs on a rising edge where valid & ready are both 1.
- Latency: if accepted at edge T, out_valid rises after edge T+NSLICE (WIDTH=16: T+4).
- The DONE→IDLE edge is the edge where out_ready=1; in_ready rises after it.
- Minimum issue interval is NSLICE+2 cycles. There is no overlap of accept and retire.
- in_ready and out_valid are decoded from registered state only; there is no combinational input→output path.
- WIDTH=4 degenerates to a single RUN cycle.

## Test plan
- Add: WIDTH=16, a=0x1234, b=0x0FFF, s=1001, m=0, cn_n=1 -> out_valid 4 cycles after accept; f=0x2233, cn4_n=1, a_b=0.
- Subtract with borrow: a=0x0005, b=0x0007, s=0110, m=0, cn_n=0 -> f=0xFFFE, cn4_n=1. Then a=0x0007, b=0x0005 -> f=0x0002, cn4_n=0.
- Compare: a=b=0x5A5A, s=0110, m=0, cn_n=1 -> f=0xFFFF, a_b=1. Then m=1, s=1011, a=0xF0F0, b=0xFF00 -> f=0xF000, a_b=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while toggling in_valid and a/b -> f, cn4_n, a_b stable; in_ready=0. On the out_ready=1 edge, return to IDLE; the next request is accepted one cycle later.
- Reset mid-RUN: assert rst 2 cycles after accept -> immediately out_valid=0, f=0, cn4_n=1, in_ready=1. The next operation (a=0x0001, b=0x0001, s=1001) yields f=0x0002.
- Parameter sweep: WIDTH=4 and WIDTH=32, random a/b/s/m/cn_n against the X/Y reference model -> f/cn4_n/a_b match; latency equals NSLICE.
